// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serialiser: byte handshake in, LSB-first bit stream with
// bit stuffing and NRZI encoding out on D+/D-, each packet closed with SE0-SE0-J.
module usb_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned STUFF_LEN    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       dp_out,
   output logic       dm_out,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned OW = $clog2(STUFF_LEN + 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [OW-1:0] O_MAX  = OW'(STUFF_LEN);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      STUFF,
      EOP_SE0,
      EOP_J
   } state_t;

   state_t        state, state_n;
   logic [7:0]    buf_data, buf_data_n;
   logic          buf_last, buf_last_n;
   logic          buf_full, buf_full_n;
   logic [7:0]    sh_reg, sh_reg_n;
   logic          sh_last, sh_last_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [OW-1:0] ones_cnt, ones_n;
   logic [TW-1:0] timer, timer_n;
   logic          se0_cnt, se0_n;
   logic          dp_r, dp_n;
   logic          dm_r, dm_n;
   logic          done_r, done_n;
   logic          err_r, err_n;

   logic          accept;
   logic          boundary;
   logic [OW-1:0] ones_inc;
   logic          nxt_bit;
   logic          byte_end;
   logic          load_en;
   logic [7:0]    load_data;
   logic          load_last;
   logic          emit;
   logic          emit_bit;

   assign accept   = tx_valid & ~buf_full;
   assign boundary = (timer == T_LAST);
   assign ones_inc = sh_reg[bit_cnt] ? (ones_cnt + OW'(1)) : '0;
   assign nxt_bit  = sh_reg[bit_cnt + 3'd1];

   assign tx_ready = ~buf_full;
   assign dp_out   = dp_r;
   assign dm_out   = dm_r;
   assign tx_busy  = (state != IDLE);
   assign tx_done  = done_r;
   assign tx_err   = err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         buf_data <= '0;
         buf_last <= 1'b0;
         buf_full <= 1'b0;
         sh_reg   <= '0;
         sh_last  <= 1'b0;
         bit_cnt  <= '0;
         ones_cnt <= '0;
         timer    <= '0;
         se0_cnt  <= 1'b0;
         dp_r     <= 1'b1;
         dm_r     <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state    <= state_n;
         buf_data <= buf_data_n;
         buf_last <= buf_last_n;
         buf_full <= buf_full_n;
         sh_reg   <= sh_reg_n;
         sh_last  <= sh_last_n;
         bit_cnt  <= bit_cnt_n;
         ones_cnt <= ones_n;
         timer    <= timer_n;
         se0_cnt  <= se0_n;
         dp_r     <= dp_n;
         dm_r     <= dm_n;
         done_r   <= done_n;
         err_r    <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      buf_data_n = buf_data;
      buf_last_n = buf_last;
      buf_full_n = buf_full;
      sh_reg_n   = sh_reg;
      sh_last_n  = sh_last;
      bit_cnt_n  = bit_cnt;
      ones_n     = ones_cnt;
      se0_n      = se0_cnt;
      dp_n       = dp_r;
      dm_n       = dm_r;
      done_n     = 1'b0;
      err_n      = 1'b0;
      timer_n    = (state == IDLE || boundary) ? '0 : timer + TW'(1);
      byte_end   = 1'b0;
      load_en    = 1'b0;
      load_data  = buf_data;
      load_last  = buf_last;
      emit       = 1'b0;
      emit_bit   = 1'b1;

      // In IDLE an accepted byte bypasses the holding buffer and goes straight to the line
      if (accept && state != IDLE) begin
         buf_data_n = tx_data;
         buf_last_n = tx_last;
         buf_full_n = 1'b1;
      end

      case (state)
         IDLE: begin
            ones_n = '0;
            if (buf_full) begin
               load_en    = 1'b1;
               buf_full_n = 1'b0;
            end else if (tx_valid) begin
               load_en   = 1'b1;
               load_data = tx_data;
               load_last = tx_last;
            end
         end
         SHIFT: begin
            if (boundary) begin
               ones_n = ones_inc;
               if (ones_inc == O_MAX) begin
                  state_n  = STUFF;
                  ones_n   = '0;
                  emit     = 1'b1;
                  emit_bit = 1'b0;
               end else if (bit_cnt != 3'd7) begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  emit      = 1'b1;
                  emit_bit  = nxt_bit;
               end else begin
                  byte_end = 1'b1;
               end
            end
         end
         STUFF: begin
            if (boundary) begin
               if (bit_cnt != 3'd7) begin
                  state_n   = SHIFT;
                  bit_cnt_n = bit_cnt + 3'd1;
                  emit      = 1'b1;
                  emit_bit  = nxt_bit;
               end else begin
                  byte_end = 1'b1;
               end
            end
         end
         EOP_SE0: begin
            if (boundary) begin
               if (se0_cnt) begin
                  state_n = EOP_J;
                  dp_n    = 1'b1;
                  dm_n    = 1'b0;
               end else begin
                  se0_n = 1'b1;
               end
            end
         end
         EOP_J: begin
            if (boundary) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // End of a byte (after any trailing stuff bit): chain the buffered byte or close the packet
      if (byte_end) begin
         if (buf_full) begin
            load_en    = 1'b1;
            buf_full_n = 1'b0;
         end else begin
            err_n   = ~sh_last;
            state_n = EOP_SE0;
            se0_n   = 1'b0;
            dp_n    = 1'b0;
            dm_n    = 1'b0;
         end
      end

      if (load_en) begin
         state_n   = SHIFT;
         sh_reg_n  = load_data;
         sh_last_n = load_last;
         bit_cnt_n = '0;
         emit      = 1'b1;
         emit_bit  = load_data[0];
      end

      if (emit && !emit_bit) begin
         dp_n = ~dp_r;
         dm_n = ~dm_r;
      end
   end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a USB bit-level model pushes expected line symbols
// per byte as it is driven; a monitor pops and compares them every clock.
module tb_usb_tx_serializer;

   localparam int CPB = 8;
   localparam int SL  = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       dp_out;
   logic       dm_out;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   usb_tx_serializer #(.CLKS_PER_BIT(CPB), .STUFF_LEN(SL)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .dp_out(dp_out), .dm_out(dm_out), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

   logic [1:0] exp_q[$];
   logic       m_j;
   int         m_ones;
   logic [1:0] obs[64];
   int         obs_n;
   int         acc_cyc[4];

   typedef struct {
      logic [31:0] data;
      int          n;
      bit          last;
      int          nsym;
      int          err;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_j    = 1'b1;
      m_ones = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) m_ones++;
         else begin
            m_j    = ~m_j;
            m_ones = 0;
         end
         exp_q.push_back(m_j ? J : K);
         if (m_ones == SL) begin
            m_j    = ~m_j;
            m_ones = 0;
            exp_q.push_back(m_j ? J : K);
         end
      end
   endtask

   task automatic model_eop();
      exp_q.push_back(SE0);
      exp_q.push_back(SE0);
      exp_q.push_back(J);
      model_reset();
   endtask

   task automatic send_pkt(input logic [31:0] data, input int n, input bit last);
      int waitc;
      for (int i = 0; i < n; i++) begin
         tx_data  = data[8*i +: 8];
         tx_valid = 1'b1;
         tx_last  = last && (i == n - 1);
         model_byte(data[8*i +: 8]);
         if (i == n - 1) model_eop();
         waitc = 0;
         while (!tx_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
         end
         if (!tx_ready) begin
            check("accept timeout", tx_ready, 1);
            tx_valid = 1'b0;
            return;
         end
         @(posedge clk);
         acc_cyc[i] = cyc;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
   endtask

   task automatic watch_packet(input string name, input int exp_cycles, input int exp_err);
      int c = 0, bad = 0, errs = 0, early_done = 0, waitc = 0;
      logic [1:0] sym = 2'b11;
      obs_n = 0;
      while (!tx_busy && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      if (!tx_busy) begin
         check($sformatf("%s busy start", name), tx_busy, 1);
         return;
      end
      while (tx_busy && c < 4000) begin
         if (c % CPB == 0) sym = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
         if (c % CPB == CPB / 2 && obs_n < 64) begin
            obs[obs_n] = {dp_out, dm_out};
            obs_n++;
         end
         if ({dp_out, dm_out} !== sym) begin
            if (bad == 0)
               $display("  %s first line difference at clk %0d: got %b expected %b",
                        name, c, {dp_out, dm_out}, sym);
            bad++;
         end
         if (tx_err) errs++;
         if (tx_done) early_done++;
         c++;
         @(negedge clk);
      end
      check($sformatf("%s line mismatches", name), bad, 0);
      check($sformatf("%s busy clks", name), c, exp_cycles);
      check($sformatf("%s tx_err pulses", name), errs, exp_err);
      check($sformatf("%s done while busy", name), early_done, 0);
      check($sformatf("%s tx_done at end", name), tx_done, 1);
      check($sformatf("%s line J after", name), {dp_out, dm_out}, J);
      check($sformatf("%s queue left", name), exp_q.size(), 0);
      @(negedge clk);
      check($sformatf("%s tx_done width", name), tx_done, 0);
   endtask

   logic [1:0] sync_pid[19];

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy_seen, pulse_seen;
      tbl[0] = '{32'h0000_2D80, 2, 1'b1, 19, 0};
      tbl[1] = '{32'h0000_00FF, 1, 1'b1, 12, 0};
      tbl[2] = '{32'h0000_3F80, 2, 1'b1, 20, 0};
      tbl[3] = '{32'h0000_00FC, 1, 1'b1, 12, 0};
      tbl[4] = '{32'h0000_03F0, 2, 1'b1, 20, 0};
      tbl[5] = '{32'h0000_0FFC, 2, 1'b1, 20, 0};
      tbl[6] = '{32'h0000_0080, 1, 1'b0, 11, 1};
      tbl[7] = '{32'h00FF_FF7F, 3, 1'b1, 30, 0};
      sync_pid = '{K, J, K, J, K, J, K, K,  K, J, J, J, K, K, J, K,  SE0, SE0, J};

      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset line", {dp_out, dm_out}, J);
      check("reset tx_ready", tx_ready, 1);
      check("reset busy", tx_busy, 0);
      check("reset done/err", {tx_done, tx_err}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset line", {dp_out, dm_out}, J);

      // reset in the middle of a byte
      send_pkt(32'h00, 1, 1'b0);
      repeat (20) @(negedge clk);
      check("midbyte busy", tx_busy, 1);
      #2 rst = 1'b1;
      #1;
      check("midbyte reset line", {dp_out, dm_out}, J);
      check("midbyte reset busy", tx_busy, 0);
      check("midbyte reset ready", tx_ready, 1);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      busy_seen = 0; pulse_seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_busy) busy_seen++;
         if (tx_done || tx_err) pulse_seen++;
      end
      check("after abort busy clks", busy_seen, 0);
      check("after abort done/err", pulse_seen, 0);

      for (int i = 0; i < 8; i++) begin
         exp_q.delete();
         model_reset();
         fork
            send_pkt(tbl[i].data, tbl[i].n, tbl[i].last);
            watch_packet($sformatf("pkt%0d", i), tbl[i].nsym * CPB, tbl[i].err);
         join
         if (i == 0) begin
            for (int k = 0; k < 19; k++)
               check($sformatf("sync_pid symbol %0d", k), obs[k], sync_pid[k]);
         end
         repeat (3) @(negedge clk);
      end

      // four bytes with tx_valid held high: one accept per byte time, no gaps
      exp_q.delete();
      model_reset();
      fork
         send_pkt(32'hCC33_AA55, 4, 1'b1);
         watch_packet("throughput", 35 * CPB, 0);
      join
      check("accept spacing 0-1", acc_cyc[1] - acc_cyc[0], 1);
      check("accept spacing 1-2", acc_cyc[2] - acc_cyc[1], 8 * CPB);
      check("accept spacing 2-3", acc_cyc[3] - acc_cyc[2], 8 * CPB);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
